// File: rtl/sop_approx_pkg.sv
// Shared types and constants for the SOP approximate-circuit evaluator.
// Literal codes, engine FSM states and the per-product configuration word.
package sop_approx_pkg;

    localparam logic [1:0] LIT_DC   = 2'b00;
    localparam logic [1:0] LIT_POS  = 2'b01;
    localparam logic [1:0] LIT_NEG  = 2'b10;
    localparam logic [1:0] LIT_ZERO = 2'b11;

    localparam int unsigned DEF_N_IN  = 4;
    localparam int unsigned DEF_N_OUT = 3;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_SWAP  = 2'd2
    } eng_state_t;

    typedef struct packed {
        logic [2*DEF_N_IN-1:0] lit;
        logic [DEF_N_OUT-1:0]  act;
    } prod_cfg_t;

    function automatic logic lit_term(input logic [1:0] code, input logic x);
        logic r;
        case (code)
            LIT_DC:   r = 1'b1;
            LIT_POS:  r = x;
            LIT_NEG:  r = ~x;
            LIT_ZERO: r = 1'b0;
            default:  r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/sop_cfg_bank.sv
// Shadow/active configuration registers for sop_approx_engine.
// Host writes land in the shadow bank; a swap copies the whole shadow bank at once.
module sop_cfg_bank
    import sop_approx_pkg::*;
#(
    parameter int unsigned N_IN   = 4,
    parameter int unsigned N_OUT  = 3,
    parameter int unsigned N_PROD = 20,
    parameter int unsigned SEL_W  = 5
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_we,
    input  logic [SEL_W-1:0]           i_sel,
    input  logic [2*N_IN-1:0]          i_lit,
    input  logic [N_OUT-1:0]           i_act,
    input  logic                       i_swap,
    output logic [N_PROD*2*N_IN-1:0]   o_lit,
    output logic [N_PROD*N_OUT-1:0]    o_act,
    output logic [N_OUT-1:0]           o_oen
);

    logic [N_PROD*2*N_IN-1:0] r_sh_lit, r_ac_lit;
    logic [N_PROD*N_OUT-1:0]  r_sh_act, r_ac_act;
    logic [N_OUT-1:0]         r_sh_oen, r_ac_oen;

    // A write in the swap cycle reaches the shadow after the copy: non-blocking reads see old shadow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sh_lit <= '0;
            r_sh_act <= '0;
            r_sh_oen <= '0;
            r_ac_lit <= '0;
            r_ac_act <= '0;
            r_ac_oen <= '0;
        end else begin
            if (i_we) begin
                for (int unsigned p = 0; p < N_PROD; p++) begin
                    if (i_sel == SEL_W'(p)) begin
                        r_sh_lit[p*2*N_IN +: 2*N_IN] <= i_lit;
                        r_sh_act[p*N_OUT +: N_OUT]   <= i_act;
                    end
                end
                if (i_sel == SEL_W'(N_PROD)) begin
                    r_sh_oen <= i_act;
                end
            end
            if (i_swap) begin
                r_ac_lit <= r_sh_lit;
                r_ac_act <= r_sh_act;
                r_ac_oen <= r_sh_oen;
            end
        end
    end

    assign o_lit = r_ac_lit;
    assign o_act = r_ac_act;
    assign o_oen = r_ac_oen;

endmodule

// File: rtl/sop_approx_engine.sv
// Two-stage pipelined shared-product SOP evaluator with atomic config commit.
// Optional abs-diff error monitor enabled by defining ABS_DIFF_ERRMON_EN.
module sop_approx_engine
    import sop_approx_pkg::*;
#(
    parameter int unsigned N_IN   = 4,
    parameter int unsigned N_OUT  = 3,
    parameter int unsigned N_PROD = 20,
    parameter int unsigned ET     = 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [N_IN-1:0]                in_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [N_OUT-1:0]               out_data,
    input  logic                           cfg_we,
    input  logic [$clog2(N_PROD+1)-1:0]    cfg_sel,
    input  logic [2*N_IN-1:0]              cfg_lit,
    input  logic [N_OUT-1:0]               cfg_act,
    input  logic                           cfg_commit,
    output logic                           cfg_busy,
    output logic [15:0]                    err_cnt,
    output logic [N_OUT:0]                 err_max
);

    localparam int unsigned SEL_W = $clog2(N_PROD+1);

    eng_state_t               r_state;
    logic                     r_busy;
    logic                     r_s1_valid, r_s2_valid;
    logic [N_PROD-1:0]        r_s1_prod;
    logic [N_OUT-1:0]         r_s2_out;

    logic                     w_s2_adv, w_accept, w_swap;
    logic [N_PROD-1:0]        w_prod;
    logic [N_OUT-1:0]         w_out;
    logic [N_PROD*2*N_IN-1:0] w_ac_lit;
    logic [N_PROD*N_OUT-1:0]  w_ac_act;
    logic [N_OUT-1:0]         w_ac_oen;

    sop_cfg_bank #(
        .N_IN   (N_IN),
        .N_OUT  (N_OUT),
        .N_PROD (N_PROD),
        .SEL_W  (SEL_W)
    ) u_bank (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_we   (cfg_we),
        .i_sel  (cfg_sel),
        .i_lit  (cfg_lit),
        .i_act  (cfg_act),
        .i_swap (w_swap),
        .o_lit  (w_ac_lit),
        .o_act  (w_ac_act),
        .o_oen  (w_ac_oen)
    );

    assign w_s2_adv  = out_ready | ~r_s2_valid;
    assign in_ready  = w_s2_adv & (r_state == ST_RUN);
    assign w_accept  = in_valid & in_ready;
    assign w_swap    = (r_state == ST_SWAP);
    assign out_valid = r_s2_valid;
    assign out_data  = r_s2_out;
    assign cfg_busy  = r_busy;

    always_comb begin
        w_prod = '1;
        for (int unsigned p = 0; p < N_PROD; p++) begin
            for (int unsigned i = 0; i < N_IN; i++) begin
                w_prod[p] = w_prod[p] & lit_term(w_ac_lit[p*2*N_IN + 2*i +: 2], in_data[i]);
            end
        end
    end

    // Bank is only swapped with both stages empty, so stage 2 may read the active bank directly.
    always_comb begin
        w_out = '0;
        for (int unsigned o = 0; o < N_OUT; o++) begin
            for (int unsigned p = 0; p < N_PROD; p++) begin
                w_out[o] = w_out[o] | (r_s1_prod[p] & w_ac_act[p*N_OUT + o]);
            end
        end
        w_out = w_out & w_ac_oen;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_prod  <= '0;
            r_s2_valid <= 1'b0;
            r_s2_out   <= '0;
        end else if (w_s2_adv) begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_prod <= w_prod;
            end
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_out <= w_out;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (cfg_commit) begin
                        r_state <= ST_DRAIN;
                        r_busy  <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (!r_s1_valid && !r_s2_valid) begin
                        r_state <= ST_SWAP;
                    end
                end
                ST_SWAP: begin
                    r_state <= ST_RUN;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_RUN;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef ABS_DIFF_ERRMON_EN
    localparam int unsigned HALF = N_IN / 2;
    localparam int unsigned EW   = N_OUT + 1;
    localparam logic [EW-1:0] ET_W = EW'(ET);

    if (N_OUT != HALF + 1) begin : g_errmon_width_check
        $error("sop_approx_engine: abs-diff monitor needs N_OUT == N_IN/2 + 1");
    end

    logic [N_IN-1:0] r_s1_in, r_s2_in;
    logic [15:0]     r_err_cnt;
    logic [EW-1:0]   r_err_max;
    logic [HALF-1:0] w_a, w_b;
    logic [EW-1:0]   w_exact, w_res, w_e;

    always_comb begin
        w_a     = r_s2_in[HALF-1:0];
        w_b     = r_s2_in[N_IN-1:HALF];
        w_exact = (w_a >= w_b) ? EW'(w_a - w_b) : EW'(w_b - w_a);
        w_res   = {1'b0, r_s2_out};
        w_e     = (w_res >= w_exact) ? (w_res - w_exact) : (w_exact - w_res);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_in   <= '0;
            r_s2_in   <= '0;
            r_err_cnt <= '0;
            r_err_max <= '0;
        end else begin
            if (w_s2_adv) begin
                if (w_accept) begin
                    r_s1_in <= in_data;
                end
                if (r_s1_valid) begin
                    r_s2_in <= r_s1_in;
                end
            end
            if (w_swap) begin
                r_err_cnt <= '0;
                r_err_max <= '0;
            end else if (r_s2_valid && out_ready) begin
                if (w_e > ET_W && r_err_cnt != 16'hFFFF) begin
                    r_err_cnt <= r_err_cnt + 16'd1;
                end
                if (w_e > r_err_max) begin
                    r_err_max <= w_e;
                end
            end
        end
    end

    assign err_cnt = r_err_cnt;
    assign err_max = r_err_max;
`else
    logic w_unused_et;
    assign w_unused_et = ^ET;
    assign err_cnt     = '0;
    assign err_max     = '0;
`endif

endmodule
